// File: rtl/mat_pkg.sv
// Shared matrix-unit definitions: state encoding, default geometry and index width.
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MAT_M       = 8;
  localparam int MAT_N       = 8;
  localparam int MAT_CHUNK_W = 8;
  localparam int MAT_CHUNKS  = 3;

  function automatic int idx_w(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/chunk_assembler.sv
// Reassembles CHUNKS consecutive beats (MSB chunk first) into one element word.
module chunk_assembler #(
  parameter int CHUNK_W = 8,
  parameter int CHUNKS  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      beat_valid,
  input  logic [CHUNK_W-1:0]        chunk_in,
  output logic [CHUNK_W*CHUNKS-1:0] word,
  output logic                      word_valid
);

  localparam int ELEM_W = CHUNK_W * CHUNKS;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHUNKS - 1);

  // Only the earlier beats are held; the current beat is appended combinationally.
  logic [ELEM_W-CHUNK_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  always_comb begin
    word       = {asm_q, chunk_in};
    word_valid = beat_valid && (cnt_q == LAST_BEAT);
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    if (clear) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (beat_valid) begin
      asm_d = word[ELEM_W-CHUNK_W-1:0];
      cnt_d = word_valid ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mat_result_rx.sv
// Matrix result receiver: buffers one m x n frame from chunk beats, then drains it row-major.
// Optional trailer checksum and chk_err port enabled by defining MAT_RESULT_RX_CHECKSUM_EN.
module mat_result_rx
  import mat_pkg::*;
#(
  parameter int m       = MAT_M,
  parameter int n       = MAT_N,
  parameter int CHUNK_W = MAT_CHUNK_W,
  parameter int CHUNKS  = MAT_CHUNKS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      chunk_valid,
  input  logic [CHUNK_W-1:0]        chunk_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CHUNK_W*CHUNKS-1:0] out_data,
  output logic [idx_w(m, n)-1:0]    out_addr,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_overrun
`ifdef MAT_RESULT_RX_CHECKSUM_EN
  ,
  output logic                      chk_err
`endif
);

  localparam int ELEM_W = CHUNK_W * CHUNKS;
  localparam int IW     = idx_w(m, n);
  localparam int NUM    = m * n;
  localparam int AW     = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       wr_idx_q, wr_idx_d;
  logic [IW-1:0]       rd_idx_q, rd_idx_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  logic                wr_en, asm_clear, beat_en, word_valid;
  logic [ELEM_W-1:0]   word;
  logic [ELEM_W-1:0]   mem_q [NUM];
`ifdef MAT_RESULT_RX_CHECKSUM_EN
  localparam logic [IW-1:0] TRAILER_IDX = IW'(NUM);
  logic [ELEM_W-1:0]   sum_q, sum_d;
  logic                chk_q, chk_d;
`endif

  assign asm_clear = start && (state_q == IDLE);
  assign beat_en   = chunk_valid && (state_q == RECV);

  chunk_assembler #(
    .CHUNK_W(CHUNK_W),
    .CHUNKS (CHUNKS)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .beat_valid(beat_en),
    .chunk_in  (chunk_in),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    wr_en        = 1'b0;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
    sum_d        = sum_q;
    chk_d        = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RECV;
          wr_idx_d = '0;
          rd_idx_d = '0;
          err_d    = 1'b0;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
          sum_d    = '0;
          chk_d    = 1'b0;
`endif
        end
      end
      RECV: begin
        if (word_valid) begin
`ifdef MAT_RESULT_RX_CHECKSUM_EN
          // The word after the last element is the sender's checksum trailer.
          if (wr_idx_q == TRAILER_IDX) begin
            chk_d        = (word != sum_q);
            state_d      = DRAIN;
            frame_done_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_idx_d = wr_idx_q + IW'(1);
            sum_d    = sum_q + word;
          end
`else
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + IW'(1);
          if (wr_idx_q == LAST_IDX) begin
            state_d      = DRAIN;
            frame_done_d = 1'b1;
          end
`endif
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_idx_d = rd_idx_q + IW'(1);
          if (rd_idx_q == LAST_IDX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A stray beat outside RECV flags the overrun even on the start edge.
    if (chunk_valid && (state_q != RECV)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
      sum_q        <= '0;
      chk_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
      sum_q        <= sum_d;
      chk_q        <= chk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx_q[AW-1:0]] <= word;
  end

  assign out_valid   = (state_q == DRAIN);
  assign out_data    = out_valid ? mem_q[rd_idx_q[AW-1:0]] : '0;
  assign out_addr    = out_valid ? rd_idx_q : '0;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign err_overrun = err_q;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
  assign chk_err     = chk_q;
`endif

endmodule

// File: tb/tb_mat_result_rx.sv
// Directed bench for mat_result_rx at m=n=3, CHUNK_W=8, CHUNKS=3.
module tb_mat_result_rx;

  localparam int M   = 3;
  localparam int N   = 3;
  localparam int NUM = M * N;
  localparam int CH  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        chunk_valid = 1'b0;
  logic [7:0]  chunk_in = 8'h00;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic [5:0]  out_addr;
  logic        busy;
  logic        frame_done;
  logic        err_overrun;
`ifdef MAT_RESULT_RX_CHECKSUM_EN
  logic        chk_err;
  logic [23:0] trailer_delta = 24'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  mat_result_rx #(.m(M), .n(N), .CHUNK_W(8), .CHUNKS(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chunk_valid(chunk_valid),
    .chunk_in   (chunk_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .err_overrun(err_overrun)
`ifdef MAT_RESULT_RX_CHECKSUM_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  typedef struct {
    logic [7:0]  base;
    bit          gaps;
    logic [3:0]  rdy;
    logic [23:0] e0;
    logic [23:0] e8;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] elem(input logic [7:0] base, input int k);
    logic [7:0] b0;
    b0 = base + 8'(3 * k);
    return {b0, 8'(b0 + 8'd1), 8'(b0 + 8'd2)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends start plus one full frame; returns at the negedge of the first DRAIN cycle.
  task automatic send_frame(input logic [7:0] base, input bit gaps);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NUM * CH; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        chunk_valid = 1'b0;
        step();
      end
      chunk_valid = 1'b1;
      chunk_in    = base + 8'(k);
      step();
    end
`ifdef MAT_RESULT_RX_CHECKSUM_EN
    begin
      logic [23:0] s;
      s = 24'd0;
      for (int k = 0; k < NUM; k++) s = s + elem(base, k);
      s = s + trailer_delta;
      for (int b = 0; b < CH; b++) begin
        chunk_valid = 1'b1;
        chunk_in    = s[23 - 8*b -: 8];
        step();
      end
    end
`endif
    chunk_valid = 1'b0;
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("first_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input logic [7:0] base, input logic [3:0] rdy,
                       input logic [23:0] e0, input logic [23:0] e8);
    int idx;
    idx = 0;
    for (int c = 0; c < 64 && idx < NUM; c++) begin
      out_ready = rdy[c % 4];
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_addr", 32'(out_addr), 32'(idx));
      check("drain_data", 32'(out_data), 32'(elem(base, idx)));
      if (out_ready) begin
        if (idx == 0) check("elem0_const", 32'(out_data), 32'(e0));
        if (idx == NUM - 1) check("elem8_const", 32'(out_data), 32'(e8));
        idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_complete", 32'(idx), 32'(NUM));
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input bit inject, input bit exp_err);
    int fd0;
    fd0 = fd_cnt;
    send_frame(v.base, v.gaps);
    check("err_after_frame", 32'(err_overrun), 32'(exp_err));
`ifdef MAT_RESULT_RX_CHECKSUM_EN
    check("chk_err", 32'(chk_err), 32'(trailer_delta != 24'd0));
`endif
    if (inject) begin
      out_ready   = 1'b0;
      chunk_valid = 1'b1;
      chunk_in    = 8'hEE;
      @(negedge clk);
      chunk_valid = 1'b0;
      check("err_in_drain", 32'(err_overrun), 32'd1);
    end
    drain(v.base, v.rdy, v.e0, v.e8);
    check("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{base: 8'h01, gaps: 1'b0, rdy: 4'b1111, e0: 24'h010203, e8: 24'h191A1B};
    vecs[1] = '{base: 8'h01, gaps: 1'b1, rdy: 4'b1001, e0: 24'h010203, e8: 24'h191A1B};
    vecs[2] = '{base: 8'h40, gaps: 1'b0, rdy: 4'b1001, e0: 24'h404142, e8: 24'h58595A};
    vecs[3] = '{base: 8'hF0, gaps: 1'b1, rdy: 4'b0101, e0: 24'hF0F1F2, e8: 24'h08090A};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err_overrun), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0, 1'b0);

    // Stray beat in IDLE sets the sticky overrun flag.
    chunk_valid = 1'b1;
    chunk_in    = 8'h99;
    step();
    chunk_valid = 1'b0;
    @(negedge clk);
    check("err_in_idle", 32'(err_overrun), 32'd1);
    step();
    check("err_sticky", 32'(err_overrun), 32'd1);

    // start clears it; a beat injected in DRAIN sets it without touching the buffer.
    run_frame('{base: 8'h22, gaps: 1'b0, rdy: 4'b1111, e0: 24'h222324, e8: 24'h3A3B3C},
              1'b1, 1'b0);

    // Simultaneous start and beat: enter RECV, discard the beat, set wins over clear.
    start       = 1'b1;
    chunk_valid = 1'b1;
    chunk_in    = 8'h77;
    step();
    start       = 1'b0;
    chunk_valid = 1'b0;
    check("start_chunk_err", 32'(err_overrun), 32'd1);
    check("start_chunk_busy", 32'(busy), 32'd1);
    run_frame('{base: 8'h50, gaps: 1'b0, rdy: 4'b1111, e0: 24'h505152, e8: 24'h68696A},
              1'b0, 1'b1);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clears_err", 32'(err_overrun), 32'd0);
    check("start_busy", 32'(busy), 32'd1);

    // Abandon a partial frame with an asynchronous reset after 13 beats.
    begin
      int fd0;
      fd0 = fd_cnt;
      for (int k = 0; k < 13; k++) begin
        chunk_valid = 1'b1;
        chunk_in    = 8'hA0 + 8'(k);
        step();
      end
      chunk_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_done", 32'(frame_done), 32'd0);
      check("async_rst_err", 32'(err_overrun), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("no_done_after_abort", 32'(fd_cnt - fd0), 32'd0);
    end
    run_frame(vecs[0], 1'b0, 1'b0);

`ifdef MAT_RESULT_RX_CHECKSUM_EN
    trailer_delta = 24'd1;
    run_frame(vecs[2], 1'b0, 1'b0);
    trailer_delta = 24'd0;
    run_frame(vecs[3], 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_result_rx.md
Name: mat_result_rx

Overview:
- Receiving end of the matrix unit's serial result readout; sits downstream of the matrix-multiply controller and its result memory.
- The readout delivers each result element as CHUNKS consecutive chunk beats. This block reassembles the beats into full elements and buffers one complete m x n result frame.
- It then drains the frame to a consumer over a valid/ready stream, tagging each element with its row-major address.

Parameters:
- m, 8, matrix row count (as in the controller)
- n, 8, matrix column count
- CHUNK_W, 8, bits per chunk beat
- CHUNKS, 3, beats per element, MSB chunk first
- ELEM_W, CHUNK_W*CHUNKS, assembled element width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  arm reception of one frame
- chunk_valid  in  1  chunk_in valid this cycle
- chunk_in  in  CHUNK_W  result chunk
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data/out_addr valid
- out_data  out  ELEM_W  buffered element
- out_addr  out  m+n  row-major element index
- busy  out  1  high in RECV or DRAIN
- frame_done  out  1  one-cycle pulse when the frame is fully buffered
- err_overrun  out  1  sticky: chunk arrived while not in RECV

Behaviour:
- Reset (async): state=IDLE; all outputs 0; chunk counter, wr_idx, rd_idx and assembly register cleared. Buffer contents are not reset.
- Buffer: m*n words of ELEM_W, register array. Indices are m+n bits wide; the compare limit is m*n computed at that width.
- IDLE:
  - start=1 -> RECV; clears counters and err_overrun in the same edge.
  - chunk_valid in IDLE sets err_overrun; data is discarded.
- RECV:
  - Each chunk_valid: assembly = {assembly[ELEM_W-CHUNK_W-1:0], chunk_in}; chunk counter increments.
  - On beat CHUNKS-1: buf[wr_idx] <= assembled word including the current chunk; wr_idx++; chunk counter -> 0.
  - Gaps (chunk_valid=0) are allowed anywhere; counters hold.
  - start during RECV is ignored.
  - When the write with wr_idx=m*n-1 occurs: next state DRAIN; frame_done=1 for exactly that next cycle (the first DRAIN cycle).
- DRAIN:
  - out_valid=1; out_data=buf[rd_idx]; out_addr=rd_idx, all registered/stable while out_ready=0.
  - Transfer when out_valid && out_ready: rd_idx++.
  - Transfer at rd_idx=m*n-1 -> IDLE; out_valid drops the next cycle.
  - chunk_valid in DRAIN sets err_overrun; data is ignored and the buffer is untouched.
- Latency: an element is readable in the buffer 1 cycle after its last chunk. First out_valid comes 1 cycle after the final chunk.
- Throughput: 1 element per cycle in DRAIN with out_ready held high.
- busy = (state != IDLE).
- Reset mid-frame: immediate return to IDLE; the partial frame is abandoned and no frame_done is issued.
- Simultaneous start and chunk_valid in IDLE: transition to RECV; the chunk is discarded and err_overrun is set (set wins over clear).

Optional Feature:
- Macro: MAT_RESULT_RX_CHECKSUM_EN.
- With the macro defined:
  - After the m*n elements, RECV expects one extra CHUNKS-beat word: the modulo-2^ELEM_W sum of all elements.
  - Adds output port chk_err (1 bit), updated when the trailer completes: 1 if the received sum differs from the locally accumulated sum, else 0. Cleared by start and by rst.
  - frame_done pulses after the trailer, not after the last element.
- Without the macro: no trailer, no chk_err port, no accumulator.

Decomposition:
- Shared package mat_pkg holds:
  - State encoding constants: IDLE=0, RECV=1, DRAIN=2.
  - Default m/n/CHUNK_W/CHUNKS constants, shared with the controller.
  - Index-width function m+n.
- One natural sub-module: chunk_assembler (shift register + beat counter, emits word and word_valid). The FSM, buffer and drain logic stay in the top.

Test Plan:
- m=n=3, CHUNK_W=8: start, then 27 back-to-back beats 0x01,0x02,0x03,... -> buf[0]=0x010203, buf[8]=0x191A1B; frame_done pulses once; 9 drain beats with out_addr 0..8.
- Random chunk_valid gaps (50%) over the same frame -> identical buffer contents and output order; frame_done pulses exactly once.
- out_ready toggled 1-0-0-1 during DRAIN -> out_data/out_addr stable while stalled; no element lost or duplicated; IDLE after addr 8 accepted.
- chunk_valid=1 in IDLE and in DRAIN -> err_overrun=1 and stays high; buffer unchanged; next start clears it.
- rst asserted after 13 beats -> outputs 0 asynchronously; a new start then a full frame -> correct data, with no stale partial chunk merged into element 0.
- With MAT_RESULT_RX_CHECKSUM_EN, correct trailer -> chk_err=0; trailer off by one -> chk_err=1; frame_done pulses after the trailer in both cases.
